// File: rtl/move_command_gen_if.sv
// Button-to-command signal bundle for move_command_gen.
// Not a valid/ready channel: command is a one-cycle strobe with no backpressure, and the buttons are raw levels.
interface move_command_gen_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       enable;
  logic [2:0] command;
  logic [3:0] btn_state;
  logic       moving;
  logic [1:0] fsm_state;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, enable,
    input  command, btn_state, moving, fsm_state
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, enable,
    output command, btn_state, moving, fsm_state
  );
endinterface

// File: rtl/move_command_gen.sv
// Debounces four push-buttons, resolves one direction and emits one-cycle
// move commands: an immediate step, then auto-repeat while the button is held.
module move_command_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input logic              clk,
  input logic              reset,
  move_command_gen_if.slave io
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  assign raw = {io.btn_down, io.btn_up, io.btn_right, io.btn_left};

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic       h_ok, v_ok;
  logic [2:0] dir;

  // Opposing buttons on one axis cancel that axis; then left > right > up > down.
  always_comb begin
    h_ok = !(stable_q[0] && stable_q[1]);
    v_ok = !(stable_q[2] && stable_q[3]);
    dir  = 3'd0;
    if (h_ok && stable_q[0])      dir = 3'd1;
    else if (h_ok && stable_q[1]) dir = 3'd2;
    else if (v_ok && stable_q[2]) dir = 3'd3;
    else if (v_ok && stable_q[3]) dir = 3'd4;
  end

  state_e      state_q, state_d;
  logic [2:0]  cur_dir_q, cur_dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        moving_q;

  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    timer_d   = timer_q;
    cmd_d     = 3'd0;
    case (state_q)
      IDLE: begin
        if (io.enable && dir != 3'd0) begin
          cmd_d     = dir;
          cur_dir_d = dir;
          timer_d   = DELAY_LOAD;
          state_d   = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!io.enable || dir == 3'd0) begin
          state_d = IDLE;
        end else if (dir != cur_dir_q) begin
          cmd_d     = dir;
          cur_dir_d = dir;
          timer_d   = DELAY_LOAD;
          state_d   = DELAY;
        end else if (timer_q == '0) begin
          cmd_d   = cur_dir_q;
          timer_d = PERIOD_LOAD;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_dir_q <= 3'd0;
      timer_q   <= '0;
      cmd_q     <= 3'd0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      timer_q   <= timer_d;
      cmd_q     <= cmd_d;
      moving_q  <= (state_d != IDLE);
    end
  end

  assign io.command   = cmd_q;
  assign io.btn_state = stable_q;
  assign io.moving    = moving_q;
  assign io.fsm_state = state_q;
endmodule

// File: doc/move_command_gen.md
Name: move_command_gen

Overview:
- Turns four raw push-button inputs (left/right/up/down) into single-cycle movement command codes for the object-location stage.
- The downstream stage applies one 5-pixel step per cycle while the command is non-zero, so this block emits exactly one-cycle pulses.
- Each press gives an immediate step, then auto-repeat after a hold delay.
- Sits between the board button pins and the object-location register.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable samples required to accept a button level change (10 ms at 25 MHz).
- REPEAT_DELAY, 12500000: cycles from first pulse to first repeat pulse while held.
- REPEAT_PERIOD, 2500000: cycles between subsequent repeat pulses.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_left  in  1  raw button, active-high, asynchronous to clk
- btn_right  in  1  raw button, active-high
- btn_up  in  1  raw button, active-high
- btn_down  in  1  raw button, active-high
- enable  in  1  0 = suppress all commands
- command  out  3  0 none, 1 left, 2 right, 3 up, 4 down; non-zero for exactly one cycle per step
- btn_state  out  4  debounced levels {down, up, right, left}
- moving  out  1  1 while FSM is not IDLE

Behaviour:
- Reset (async, active-high): command=0, btn_state=0, moving=0, FSM=IDLE, all synchronizer flops, debounce counters and timers = 0.
- Synchronization: each button passes through a 2-flop synchronizer.
- Debounce, per button:
  - Counter increments on each edge where the synchronized value differs from the stable value.
  - Counter clears on any edge where they are equal.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, the stable value flips and the counter clears.
  - btn_state is the stable values.
- Direction resolve (combinational on btn_state):
  - If left and right are both set, the horizontal axis is ignored.
  - If up and down are both set, the vertical axis is ignored.
  - Among the remaining directions, priority is left > right > up > down; the result is dir (0 if none).
- command is registered, 0 by default every cycle.
- FSM states IDLE, DELAY, REPEAT; timer width is clog2 of max(REPEAT_DELAY, REPEAT_PERIOD).
- IDLE:
  - If enable=1 and dir≠0: command<=dir, latch cur_dir=dir, timer<=REPEAT_DELAY-1, go to DELAY.
- DELAY and REPEAT, evaluated in this order:
  - If enable=0 or dir=0: go to IDLE, no pulse.
  - Else if dir≠cur_dir: command<=dir, cur_dir<=dir, timer<=REPEAT_DELAY-1, go to DELAY.
  - Else if timer=0: command<=cur_dir, timer<=REPEAT_PERIOD-1, go to REPEAT.
  - Else timer<=timer-1.
- Latency: raw rise to first command pulse = 2 + DEBOUNCE_CYCLES + 1 rising edges.
- While held: pulses spaced REPEAT_DELAY edges (first to second), then REPEAT_PERIOD edges apart.
- enable falling mid-hold: the next edge returns to IDLE and command stays 0. Debounce keeps running.
- When enable returns with a button still held, a fresh first pulse is emitted on the next edge.
- Glitches shorter than DEBOUNCE_CYCLES never change btn_state and never produce a command.
- Reset asserted mid-repeat: outputs clear immediately, without waiting for a clock edge.
- moving = (state≠IDLE), registered.

Test Plan (overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset check: assert reset, enable=1, pulse btn_left before edge 1 and keep it high. Expect btn_state[0]=1 after edge 6 and command=1 for exactly one cycle after edge 7, 0 otherwise.
- Auto-repeat: hold btn_right from edge 1 through edge 50. Expect command=2 pulses after edges 7, 27, 35, 43 only; moving=1 from edge 7.
- Bounce filtering: btn_up toggles with a 3-cycle-high/2-cycle-low pattern for 30 cycles. Expect btn_state[2]=0 and command=0 throughout.
- Opposing/priority handling:
  - Hold left+right: command stays 0.
  - Then add down (debounced): one command=4 pulse.
  - Release right so that left becomes the active direction: immediate command=1 and the repeat timer restarts (next pulse 20 edges later).
- Enable gating: hold btn_down with enable=0 for 40 cycles: command=0, moving=0. Raise enable: command=4 on the next edge, then 20 edges later.
- Async reset mid-REPEAT: assert reset between clock edges. command, moving and btn_state read 0 before the next edge. Release with the button still held: the first pulse occurs 7 edges later.
